// File: rtl/hssi_ets_ts_buffer_pkg.sv
// Shared ETS timestamp types: field widths and the packed buffer entry.
package hssi_ets_ts_buffer_pkg;

  localparam int unsigned TS_SEC_W  = 48;
  localparam int unsigned TS_NS_W   = 32;
  localparam int unsigned TS_FNS_W  = 16;
  localparam int unsigned TS_DATA_W = TS_SEC_W + TS_NS_W + TS_FNS_W;
  localparam int unsigned TS_FP_W   = 32;

  typedef struct packed {
    logic [TS_SEC_W-1:0] sec;
    logic [TS_NS_W-1:0]  ns;
    logic [TS_FNS_W-1:0] fns;
  } ts_data_t;

  typedef struct packed {
    logic [TS_FP_W-1:0] fp;
    ts_data_t           data;
  } ts_entry_t;

  localparam int unsigned TS_ENTRY_W = $bits(ts_entry_t);

endpackage

// File: rtl/hssi_ets_ts_buf_ram.sv
// Timestamp entry storage: DEPTH x 128 simple dual-port, registered write,
// asynchronous read.
module hssi_ets_ts_buf_ram
  import hssi_ets_ts_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  ts_entry_t     wr_entry,
  input  logic [AW-1:0] rd_addr,
  output ts_entry_t     rd_entry
);

  ts_entry_t mem [DEPTH];

  // Write port: entry lands at the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_entry;
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/hssi_ets_ts_buffer.sv
// Egress timestamp buffer: show-ahead FIFO between the timestamp adapter and
// an AVST sink, with sticky overflow flag and saturating drop counter.
module hssi_ets_ts_buffer
  import hssi_ets_ts_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned CNT_WIDTH = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 asi_timestamp_fp_valid,
  input  logic [TS_DATA_W-1:0] asi_timestamp_data,
  input  logic [TS_FP_W-1:0]   asi_timestamp_fp,
  output logic                 aso_ts_valid,
  input  logic                 aso_ts_ready,
  output logic [TS_DATA_W-1:0] aso_ts_data,
  output logic [TS_FP_W-1:0]   aso_ts_fp,
  input  logic                 ovf_clr,
  output logic [AW:0]          fill_level,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  ts_entry_t     wr_entry;
  ts_entry_t     rd_entry;

  assign wr_entry = {asi_timestamp_fp, asi_timestamp_data};

  // Handshake decode; a full buffer still accepts when a read frees a slot.
  always_comb begin
    full  = (fill_level == FULL_LVL);
    rd_en = aso_ts_valid && aso_ts_ready;
    wr_en = asi_timestamp_fp_valid && (!full || rd_en);
    drop  = asi_timestamp_fp_valid && full && !rd_en;
  end

  hssi_ets_ts_buf_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_ptr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr),
    .rd_entry (rd_entry)
  );

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: +1 write only, -1 read only, unchanged otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_level <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Drop accounting; a drop coinciding with a clear restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)             drop_cnt <= CNT_WIDTH'(1);
      else if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Outputs are zero whenever empty, so reset also clears the data outputs.
  assign aso_ts_valid = (fill_level != '0);
  assign aso_ts_fp    = aso_ts_valid ? rd_entry.fp   : '0;
  assign aso_ts_data  = aso_ts_valid ? rd_entry.data : '0;

endmodule

// File: doc/hssi_ets_ts_buffer.md
HSSI_ETS_TS_BUFFER -- requirements
Module: hssi_ets_ts_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, buffer entries (power of two, 4..256).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, drop counter width.
REQ-003 SHALL provide ports: clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL provide ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL provide ports: asi_timestamp_fp_valid  in  1  egress timestamp strobe from the timestamp adapter, no backpressure.
REQ-006 SHALL provide ports: asi_timestamp_data  in  96  timestamp {sec[47:0], ns[31:0], fns[15:0]}.
REQ-007 SHALL provide ports: asi_timestamp_fp  in  32  fingerprint, zero-extended.
REQ-008 SHALL provide ports: aso_ts_valid  out  1, aso_ts_ready  in  1, aso_ts_data  out  96, aso_ts_fp  out  32  buffered AVST source.
REQ-009 SHALL provide ports: ovf_clr  in  1  clears sticky overflow and drop counter.
REQ-010 SHALL provide ports: fill_level  out  clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL provide ports: overflow  out  1  sticky drop flag.
REQ-012 SHALL provide ports: drop_cnt  out  CNT_WIDTH  dropped-timestamp count.

Function
REQ-013 SHALL store each accepted {fp, data} pair as one 128-bit entry in FIFO order.
REQ-014 SHALL accept a write when asi_timestamp_fp_valid=1 and (fill_level<DEPTH or a read occurs the same cycle).
REQ-015 SHALL, when full with no same-cycle read, discard the incoming entry and keep stored entries intact.
REQ-016 SHALL define a read as aso_ts_valid=1 and aso_ts_ready=1 in the same cycle.
REQ-017 SHALL drive aso_ts_valid=1 exactly when fill_level>0, show-ahead, with aso_ts_data/aso_ts_fp showing the oldest entry.
REQ-018 SHALL present an entry written in cycle N at the output no earlier than cycle N+1: one-cycle write-to-valid latency, no input-to-output combinational path.
REQ-019 SHALL hold aso_ts_data/aso_ts_fp stable while aso_ts_valid=1 and aso_ts_ready=0.
REQ-020 SHALL update fill_level each cycle by +1 (write only), -1 (read only) or 0 (both or neither).
REQ-021 SHALL wrap read and write pointers modulo DEPTH; full/empty derived from fill_level, not pointer equality alone.
REQ-022 SHALL set overflow on every discarded write and hold it until ovf_clr or reset.
REQ-023 SHALL increment drop_cnt by 1 per discarded write, saturating at all-ones.
REQ-024 SHALL let a drop take priority over ovf_clr in the same cycle: result is overflow=1, drop_cnt=1.
REQ-025 SHALL ignore aso_ts_ready while empty; no underflow, pointers unchanged.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force aso_ts_valid=0, fill_level=0, overflow=0, drop_cnt=0, pointers=0, aso_ts_data=0, aso_ts_fp=0.
REQ-027 SHALL discard all buffered entries on reset assertion mid-operation; no entry survives reset.
REQ-028 SHALL release reset synchronously to clk (external synchronizer) and accept writes from the first cycle after deassertion.

Structure
REQ-029 SHALL take the 96-bit timestamp field widths and the 32-bit fingerprint width from the shared ets timestamp package, together with the packed 128-bit entry typedef.
REQ-030 SHALL implement storage as one sub-module, hssi_ets_ts_buf_ram: DEPTH x 128 simple dual-port, registered write, asynchronous read.
REQ-031 SHALL keep pointers, occupancy, overflow and drop-count control in the top module.

Verification
REQ-032 SHALL cover basic: 3 writes (fp=1,2,3), ready=1 -> outputs in order 1,2,3; each valid one cycle after its write; fill_level returns to 0.
REQ-033 SHALL cover full plus drop: DEPTH=16, ready=0, 18 writes -> fill_level=16, overflow=1, drop_cnt=2, reads return fp 0..15.
REQ-034 SHALL cover full with simultaneous read: full, write fp=0xAA with ready=1 -> write accepted, fill_level stays 16, drop_cnt unchanged, 0xAA read last.
REQ-035 SHALL cover saturation and clear: CNT_WIDTH=4, 20 drops -> drop_cnt=15; ovf_clr pulse -> 0/0; ovf_clr coincident with a drop -> overflow=1, drop_cnt=1.
REQ-036 SHALL cover backpressure hold: ready toggled 0/1 randomly over 100 entries -> no loss, no duplication, outputs stable while stalled.
REQ-037 SHALL cover reset mid-stream: rst_n low with 5 entries stored -> aso_ts_valid=0 and fill_level=0 immediately; after release, first new write is read first.
